program_memory_loader: RTL and testbench

//  Write-side counterpart of the asynchronous-read program ROM: accepts a byte stream (UART/JTAG bridge),

---
 rtl/program_loader_pkg.sv | 29 ++
 rtl/byte_word_packer.sv | 47 ++++
 rtl/program_memory_loader.sv | 184 ++++++++++++++++++
 tb/tb_program_memory_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// ---------------------------------------------------------------------------
// program_loader_pkg
// Shared types and constants for the program memory loader.
//   loader_state_t  : loader FSM states (CHECK is only reachable when the
//                     design is built with LOADER_CHECKSUM_EN defined)
//   BYTES_PER_WORD  : stream bytes packed into one instruction word
//   LEN_BYTES       : bytes in the little-endian word-count header
// ---------------------------------------------------------------------------
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

    // States in which the loader takes bytes from the stream.
    function automatic logic takes_bytes(input loader_state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// ---------------------------------------------------------------------------
// byte_word_packer
// Collects stream bytes into little-endian 32-bit words (first byte lands in
// word[7:0]).
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : drop any partial word (start of a new session)
//   take        : a data byte is transferred this cycle
//   byte_data   : the byte being transferred
//   word_valid  : combinational, high in the cycle the 4th byte is taken
//   word        : combinational, the completed word while word_valid is high
// The first three bytes are held in a shift register; the 4th byte is
// inserted on the fly so the caller can register the word in the same cycle.
// ---------------------------------------------------------------------------
module byte_word_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] count;
    logic [23:0]      lower;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            lower <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (take) begin
            count <= count + CNT_W'(1);
            // Shift right so that after three bytes the oldest sits in [7:0].
            lower <= {byte_data, lower[23:8]};
        end
    end

    assign word_valid = take && (count == CNT_W'(BYTES_PER_WORD - 1));
    assign word       = {byte_data, lower};

endmodule

// File: rtl/program_memory_loader.sv
// ---------------------------------------------------------------------------
// program_memory_loader
// Receives a byte stream (LEN_LO, LEN_HI, then 4*N little-endian instruction
// bytes), writes the words to sequential addresses of the program memory and
// holds the CPU in reset while loading.
// Optional feature macro: LOADER_CHECKSUM_EN -- one trailer byte follows the
// data; it must equal the 8-bit wrapping sum of the length and data bytes,
// otherwise the session ends in ERROR (words already written stay written).
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             1-cycle pulse that opens a session (ignored while busy)
//   byte_data/valid   incoming stream byte
//   byte_ready        loader accepts a byte this cycle
//   wr_en/address/data  registered word write, wr_address is a byte address
//   busy, cpu_hold    session in progress (covers the final write cycle)
//   done, load_error  sticky session result, cleared by the next start
//   dbg_state         current FSM state
// Handshake: a byte moves exactly in a cycle where byte_valid && byte_ready;
// byte_ready depends only on the FSM state (never on byte_valid) and the
// loader never stalls, so a source may present one byte every cycle.
// ---------------------------------------------------------------------------
module program_memory_loader
    import program_loader_pkg::*;
#(
    parameter int MEMORY_DEPTH = 64,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_address,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  load_error,
    output logic                  cpu_hold,
    output loader_state_t         dbg_state
);

    localparam int IDX_W = $clog2(MEMORY_DEPTH + 1);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_DATA = CHECK;
`else
    localparam loader_state_t AFTER_DATA = DONE;
`endif

    loader_state_t    state;
    loader_state_t    next_state;
    logic [7:0]       len_lo;
    logic [15:0]      len_words;
    logic [IDX_W-1:0] word_index;
    logic [15:0]      len_now;
    logic             take;
    logic             session_start;
    logic             last_word;
    logic             pack_valid;
    logic [31:0]      pack_word;

    assign take          = byte_valid && byte_ready;
    assign session_start = start && !busy;
    assign len_now       = {byte_data, len_lo};
    // word_index counts words already written, so this is the final word.
    assign last_word     = (16'(word_index) + 16'd1) == len_words;
    assign dbg_state     = state;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else if (session_start) begin
            sum <= '0;
        end else if (take && (state != CHECK)) begin
            sum <= sum + byte_data;
        end
    end
`endif

    byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (session_start),
        .take       (take && (state == DATA)),
        .byte_data  (byte_data),
        .word_valid (pack_valid),
        .word       (pack_word)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (session_start) begin
                    next_state = LEN_LO;
                end
            end
            LEN_LO: begin
                if (take) begin
                    next_state = LEN_HI;
                end
            end
            LEN_HI: begin
                if (take) begin
                    if (len_now == 16'd0) begin
                        next_state = AFTER_DATA;
                    end else if (len_now > 16'(MEMORY_DEPTH)) begin
                        next_state = ERROR;
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            DATA: begin
                if (pack_valid && last_word) begin
                    next_state = AFTER_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (take) begin
                    next_state = (byte_data == sum) ? DONE : ERROR;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // Outputs. The final word write happens one cycle after DONE/CHECK is
    // entered, so busy is extended by wr_en and done waits for it to clear.
    always_comb begin
        byte_ready = takes_bytes(state);
        busy       = byte_ready || wr_en;
        cpu_hold   = busy;
        done       = ((state == DONE) || (state == ERROR)) && !wr_en;
        load_error = (state == ERROR);
    end

    // Length capture, word index and registered memory write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_lo     <= '0;
            len_words  <= '0;
            word_index <= '0;
            wr_en      <= 1'b0;
            wr_address <= '0;
            wr_data    <= '0;
        end else begin
            wr_en <= 1'b0;
            if (session_start) begin
                word_index <= '0;
            end
            if (take && (state == LEN_LO)) begin
                len_lo <= byte_data;
            end
            if (take && (state == LEN_HI)) begin
                len_words <= len_now;
            end
            if (pack_valid) begin
                wr_en      <= 1'b1;
                wr_data    <= DATA_WIDTH'(pack_word);
                wr_address <= DATA_WIDTH'(word_index) << 2;
                word_index <= word_index + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_program_memory_loader.sv
// ---------------------------------------------------------------------------
// tb_program_memory_loader
// Drives load frames into program_memory_loader and compares every memory
// write, the session result and the handshake/status outputs against a
// frame-level model: a frame of N words yields writes (4k, word k) for
// k < N when N <= DEPTH, and the result flags follow from N (and from the
// trailer byte when LOADER_CHECKSUM_EN is defined).
// ---------------------------------------------------------------------------
module tb_program_memory_loader;
    import program_loader_pkg::*;

    localparam int DEPTH = 64;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    // Clock / reset / DUT.
    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_ready;
    logic          wr_en;
    logic [31:0]   wr_address;
    logic [31:0]   wr_data;
    logic          busy;
    logic          done;
    logic          load_error;
    logic          cpu_hold;
    loader_state_t dbg_state;

    always #5 clk = ~clk;

    program_memory_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .load_error (load_error),
        .cpu_hold   (cpu_hold),
        .dbg_state  (dbg_state)
    );

    // Scoreboard state: {due_cycle, address, data} per expected write.
    logic [95:0] exp_q[$];
    logic [31:0] cyc = 32'd0;
    logic [31:0] words[DEPTH];
    int          n_pass  = 0;
    int          n_total = 0;
    bit          use_gaps   = 1'b0;
    bit          use_starts = 1'b0;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Write monitor: every wr_en must match the oldest expected write and
    // arrive exactly on its due cycle; status invariants are checked each cycle.
    always @(negedge clk) begin
        check("cpu_hold_eq_busy", cpu_hold, busy);
        check("busy_done_excl", busy & done, 1'b0);
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr", wr_en, 1'b0);
            end else begin
                logic [95:0] e;
                e = exp_q.pop_front();
                check("wr_cycle", cyc, e[95:64]);
                check("wr_address", wr_address, e[63:32]);
                check("wr_data", wr_data, e[31:0]);
                check("busy_at_wr", busy, 1'b1);
            end
        end else if (exp_q.size() != 0 && exp_q[0][95:64] < cyc) begin
            check("wr_missing", wr_en, 1'b1);
            void'(exp_q.pop_front());
        end
    end

    // Driver tasks. All driving happens at the falling edge; a byte set up at
    // one falling edge transfers on the following rising edge.
    task automatic send_byte(input logic [7:0] b, input bit push, input logic [63:0] wr);
        if (use_gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        check("byte_ready", byte_ready, 1'b1);
        byte_data  = b;
        byte_valid = 1'b1;
        if (use_starts) start = ($urandom_range(0, 2) == 0);
        if (push) exp_q.push_back({cyc + 32'd1, wr});
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(input bit exp_err);
        int t = 0;
        while (!done && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("done", done, 1'b1);
        check("load_error", load_error, exp_err);
        check("busy_end", busy, 1'b0);
        check("byte_ready_end", byte_ready, 1'b0);
        check("pending_writes", exp_q.size(), 0);
    endtask

    // Full session for word count n using words[]; bad_sum corrupts the trailer.
    task automatic run_frame(input logic [15:0] n, input bit bad_sum);
        logic [7:0] sum;
        bit         ovf;
        bit         exp_err;
        ovf     = (n > DEPTH);
        exp_err = ovf || (CHK_EN && bad_sum);
        pulse_start();
        send_byte(n[7:0], 1'b0, 64'd0);
        send_byte(n[15:8], 1'b0, 64'd0);
        sum = n[7:0] + n[15:8];
        if (!ovf) begin
            for (int k = 0; k < int'(n); k++) begin
                for (int j = 0; j < 4; j++) begin
                    logic [7:0] b;
                    b = words[k][8*j +: 8];
                    sum = sum + b;
                    send_byte(b, j == 3, {32'(4 * k), words[k]});
                end
            end
            if (CHK_EN) send_byte(bad_sum ? sum + 8'd1 : sum, 1'b0, 64'd0);
        end
        wait_done(exp_err);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, byte_ready, 1'b0);
        check({tag, "_wr_en"}, wr_en, 1'b0);
        check({tag, "_wr_address"}, wr_address, 32'd0);
        check({tag, "_wr_data"}, wr_data, 32'd0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_load_error"}, load_error, 1'b0);
        check({tag, "_cpu_hold"}, cpu_hold, 1'b0);
        check({tag, "_state"}, dbg_state, IDLE);
    endtask

    task automatic set_example_words();
        words[0] = 32'h12345678;
        words[1] = 32'hDEADBEEF;
    endtask

    task automatic randomize_words(input int n);
        for (int k = 0; k < n; k++) words[k] = $urandom;
    endtask

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Stimulus.
    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_data  = 8'd0;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);

        // Two-word example frame.
        set_example_words();
        run_frame(16'd2, 1'b0);

        // Empty frame: no writes.
        run_frame(16'd0, 1'b0);

        // One word over the memory depth, then stray bytes are refused.
        run_frame(16'd65, 1'b0);
        byte_valid = 1'b1;
        byte_data  = 8'($urandom);
        repeat (3) begin
            @(negedge clk);
            check("ready_after_error", byte_ready, 1'b0);
        end
        byte_valid = 1'b0;

        // Gaps between bytes and start pulses during the load.
        use_gaps   = 1'b1;
        use_starts = 1'b1;
        set_example_words();
        run_frame(16'd2, 1'b0);
        use_gaps   = 1'b0;
        use_starts = 1'b0;

        // Reset after five data bytes aborts at once; a fresh session loads.
        pulse_start();
        send_byte(8'h02, 1'b0, 64'd0);
        send_byte(8'h00, 1'b0, 64'd0);
        for (int j = 0; j < 5; j++) begin
            send_byte(words[j / 4][8*(j % 4) +: 8], j == 3, {32'd0, words[0]});
        end
        reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        run_frame(16'd2, 1'b0);

        // Random frames, alternating with and without byte gaps.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 12);
            randomize_words(n);
            use_gaps = r[0];
            run_frame(16'(n), 1'b0);
        end
        use_gaps = 1'b0;

        // Full memory (last address 0xFC) and an overflow in the high byte.
        randomize_words(DEPTH);
        run_frame(16'(DEPTH), 1'b0);
        run_frame(16'h0100, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Wrong trailer: words still written, session ends in error.
        set_example_words();
        run_frame(16'd2, 1'b1);
        run_frame(16'd2, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
